// File: rtl/new_ram_4.sv
`timescale 1ns/1ps
// new_ram_4
// Mixed-width pseudo-dual-port RAM, 8192 bits total. Port A writes 2-bit
// words (4096 x 2), port B reads 4-bit words (2048 x 4). One clock for both.
//
// Ports:
//   Clock     - single rising-edge clock for both ports
//   Reset     - asynchronous active-high; clears the read registers only
//   DataInA   - 2-bit write data
//   AddressA  - 12-bit write address
//   ClockEnA  - port A enable; a write needs ClockEnA and WrA both high
//   WrA       - write strobe
//   AddressB  - 11-bit read address
//   ClockEnB  - port B enable; low freezes every port B register
//   QB        - 4-bit read data, word n = {mem[2n+1], mem[2n]}
//
// Parameter REGMODE: "NOREG" gives 1-cycle read latency, "OUTREG" adds an
// output register for 2-cycle latency.

module new_ram_4 #(
  parameter string REGMODE = "NOREG"
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  DataInA,
  input  logic [11:0] AddressA,
  input  logic        ClockEnA,
  input  logic        WrA,
  input  logic [10:0] AddressB,
  input  logic        ClockEnB,
  output logic [3:0]  QB
);

  // Storage is kept in the wide (read-side) shape. A narrow write lands in
  // one 2-bit lane of a wide word: the even narrow address is the low lane,
  // the odd one the high lane. Contents power up as zero.
  logic [3:0] mem [0:2047] = '{default: 4'h0};
  logic [3:0] rd_q;

  always_ff @(posedge Clock) begin
    if (ClockEnA && WrA) begin
      if (AddressA[0]) begin
        mem[AddressA[11:1]][3:2] <= DataInA;
      end else begin
        mem[AddressA[11:1]][1:0] <= DataInA;
      end
    end
  end

  // The read register samples the array before this edge's write lands, so
  // a same-edge read of the written word returns the old contents.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_q <= 4'h0;
    end else if (ClockEnB) begin
      rd_q <= mem[AddressB];
    end
  end

  generate
    if (REGMODE == "OUTREG") begin : g_outreg
      logic [3:0] out_q;

      // Second pipeline stage shares the port B enable so the whole read
      // path freezes together.
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          out_q <= 4'h0;
        end else if (ClockEnB) begin
          out_q <= rd_q;
        end
      end

      assign QB = out_q;
    end else begin : g_noreg
      assign QB = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_new_ram_4.sv
`timescale 1ns/1ps
// tb_new_ram_4
// Drives one NOREG and one OUTREG instance from shared inputs and compares
// both outputs against a narrow-memory reference model.

module tb_new_ram_4;

  logic        clk;
  logic        rst;
  logic [1:0]  din_a;
  logic [11:0] addr_a;
  logic        cea;
  logic        wra;
  logic [10:0] addr_b;
  logic        ceb;
  logic [3:0]  qb_n;
  logic [3:0]  qb_o;

  int n_checks;
  int n_fail;

  // Reference model: the memory as the loader sees it (4096 x 2) plus the
  // values each output is expected to show.
  logic [1:0] model_mem [0:4095];
  logic [3:0] exp_rd;
  logic [3:0] exp_out;

  new_ram_4 #(.REGMODE("NOREG")) dut_noreg (
    .Clock(clk), .Reset(rst), .DataInA(din_a), .AddressA(addr_a),
    .ClockEnA(cea), .WrA(wra), .AddressB(addr_b), .ClockEnB(ceb), .QB(qb_n)
  );

  new_ram_4 #(.REGMODE("OUTREG")) dut_outreg (
    .Clock(clk), .Reset(rst), .DataInA(din_a), .AddressA(addr_a),
    .ClockEnA(cea), .WrA(wra), .AddressB(addr_b), .ClockEnB(ceb), .QB(qb_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and update the model the way the spec reads:
  // the read sees memory as it was before this edge's write.
  task automatic step();
    @(posedge clk);
    if (!rst && ceb) begin
      exp_out = exp_rd;
      exp_rd  = {model_mem[{addr_b, 1'b1}], model_mem[{addr_b, 1'b0}]};
    end
    if (cea && wra) model_mem[addr_a] = din_a;
    #1;
  endtask

  task automatic write_narrow(input logic [11:0] a, input logic [1:0] d);
    addr_a = a; din_a = d; cea = 1'b1; wra = 1'b1;
    step();
    cea = 1'b0; wra = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    exp_rd = 4'h0; exp_out = 4'h0;
    #1;
    n_checks++;
    if (qb_n !== 4'h0) begin
      n_fail++; $display("[TB] FAIL reset_noreg: got %h expected 0", qb_n);
    end
    n_checks++;
    if (qb_o !== 4'h0) begin
      n_fail++; $display("[TB] FAIL reset_outreg: got %h expected 0", qb_o);
    end
    step();
    rst = 1'b0;
    addr_b = 11'h005; ceb = 1'b1;
    step();
    n_checks++;
    if (qb_n !== 4'h0) begin
      n_fail++; $display("[TB] FAIL powerup_read: got %h expected 0", qb_n);
    end
    ceb = 1'b0;
  endtask

  task automatic test_wide_read();
    write_narrow(12'hFFF, 2'b10);
    addr_b = 11'h7FF; ceb = 1'b1;
    step();
    n_checks++;
    if (qb_n !== 4'b1000) begin
      n_fail++; $display("[TB] FAIL wide_read: got %b expected 1000", qb_n);
    end
    ceb = 1'b0;
  endtask

  task automatic test_lane_packing();
    write_narrow(12'h002, 2'b01);
    write_narrow(12'h003, 2'b11);
    addr_b = 11'h001; ceb = 1'b1;
    step();
    n_checks++;
    if (qb_n !== 4'b1101) begin
      n_fail++; $display("[TB] FAIL lane_packing: got %b expected 1101", qb_n);
    end
    ceb = 1'b0;
  endtask

  task automatic test_write_gating();
    addr_a = 12'h000; din_a = 2'b11; cea = 1'b0; wra = 1'b1;
    step();
    cea = 1'b1; wra = 1'b0;
    step();
    cea = 1'b0;
    addr_b = 11'h000; ceb = 1'b1;
    step();
    n_checks++;
    if (qb_n !== 4'h0) begin
      n_fail++; $display("[TB] FAIL write_gating: got %h expected 0", qb_n);
    end
    ceb = 1'b0;
  endtask

  task automatic test_read_during_write();
    write_narrow(12'h000, 2'b01);
    addr_a = 12'h000; din_a = 2'b10; cea = 1'b1; wra = 1'b1;
    addr_b = 11'h000; ceb = 1'b1;
    step();
    cea = 1'b0; wra = 1'b0;
    n_checks++;
    if (qb_n !== 4'b0001) begin
      n_fail++; $display("[TB] FAIL rdw_old: got %b expected 0001", qb_n);
    end
    step();
    n_checks++;
    if (qb_n !== 4'b0010) begin
      n_fail++; $display("[TB] FAIL rdw_new: got %b expected 0010", qb_n);
    end
    n_checks++;
    if (qb_o !== 4'b0001) begin
      n_fail++; $display("[TB] FAIL rdw_outreg: got %b expected 0001", qb_o);
    end
    ceb = 1'b0;
  endtask

  task automatic test_outreg_hold_reset();
    write_narrow(12'h010, 2'b11);
    write_narrow(12'h011, 2'b10);
    addr_b = 11'h008; ceb = 1'b1;
    step();
    n_checks++;
    if (qb_o !== exp_out) begin
      n_fail++; $display("[TB] FAIL outreg_lat1: got %b expected %b", qb_o, exp_out);
    end
    step();
    n_checks++;
    if (qb_o !== 4'b1011) begin
      n_fail++; $display("[TB] FAIL outreg_lat2: got %b expected 1011", qb_o);
    end
    // Freeze port B while the address moves.
    ceb = 1'b0; addr_b = 11'h000;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (qb_o !== 4'b1011) begin
      n_fail++; $display("[TB] FAIL hold_outreg: got %b expected 1011", qb_o);
    end
    n_checks++;
    if (qb_n !== 4'b1011) begin
      n_fail++; $display("[TB] FAIL hold_noreg: got %b expected 1011", qb_n);
    end
    // Put a read in flight, then reset between edges.
    ceb = 1'b1; addr_b = 11'h001;
    step();
    rst = 1'b1;
    exp_rd = 4'h0; exp_out = 4'h0;
    #1;
    n_checks++;
    if (qb_o !== 4'h0 || qb_n !== 4'h0) begin
      n_fail++; $display("[TB] FAIL reset_midread: got %h/%h expected 0/0", qb_n, qb_o);
    end
    // Writes still land while reset holds the read side.
    write_narrow(12'h020, 2'b01);
    n_checks++;
    if (qb_o !== 4'h0 || qb_n !== 4'h0) begin
      n_fail++; $display("[TB] FAIL reset_hold: got %h/%h expected 0/0", qb_n, qb_o);
    end
    rst = 1'b0;
    addr_b = 11'h010;
    step();
    n_checks++;
    if (qb_n !== 4'b0001) begin
      n_fail++; $display("[TB] FAIL write_in_reset: got %b expected 0001", qb_n);
    end
    step();
    n_checks++;
    if (qb_o !== 4'b0001) begin
      n_fail++; $display("[TB] FAIL write_in_reset_outreg: got %b expected 0001", qb_o);
    end
    ceb = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (rst) begin
        if ($urandom_range(0, 3) == 0) rst = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        exp_rd = 4'h0; exp_out = 4'h0;
      end
      addr_a = 12'h100 + 12'($urandom_range(0, 15));
      din_a  = 2'($urandom);
      cea    = ($urandom_range(0, 3) != 0);
      wra    = ($urandom_range(0, 2) != 0);
      addr_b = 11'h080 + 11'($urandom_range(0, 7));
      ceb    = ($urandom_range(0, 3) != 0);
      step();
      n_checks++;
      if (qb_n !== exp_rd) begin
        n_fail++; $display("[TB] FAIL random_noreg cycle %0d: got %h expected %h", i, qb_n, exp_rd);
      end
      n_checks++;
      if (qb_o !== exp_out) begin
        n_fail++; $display("[TB] FAIL random_outreg cycle %0d: got %h expected %h", i, qb_o, exp_out);
      end
    end
    rst = 1'b0; cea = 1'b0; wra = 1'b0; ceb = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0; din_a = 2'b00; addr_a = 12'h000; cea = 1'b0; wra = 1'b0;
    addr_b = 11'h000; ceb = 1'b0;
    exp_rd = 4'h0; exp_out = 4'h0;
    for (int i = 0; i < 4096; i++) model_mem[i] = 2'b00;

    test_reset();
    test_wide_read();
    test_lane_packing();
    test_write_gating();
    test_read_during_write();
    test_outreg_hold_reset();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
